// File: rtl/rx_gearbox.sv
// rx_gearbox: 32-bit to 66-bit receive gearbox with bit-slip alignment.
// Optional build macro: RX_GEARBOX_SLIP_HOLDOFF_EN (slip holdoff of two blocks).
//
// Ports:
//   i_clk         rx clock, rising edge
//   i_reset_n     asynchronous active-low reset
//   i_data        32 received bits, i_data[0] earliest
//   i_data_valid  i_data accepted this cycle
//   i_slip        request to shift alignment by one bit
//   o_hdr         2-bit sync header (first two bits of the block)
//   o_data        64-bit block payload
//   o_hdr_valid   single-cycle pulse per block
//   o_data_valid  same timing as o_hdr_valid
module rx_gearbox #(
    parameter int DATA_WIDTH = 32,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_valid,
    input  logic                  i_slip,
    output logic [HDR_WIDTH-1:0]  o_hdr,
    output logic [63:0]           o_data,
    output logic                  o_hdr_valid,
    output logic                  o_data_valid
);

    localparam int PAY_W = 64;
    localparam int BLK_W = HDR_WIDTH + PAY_W;
    localparam int BUF_W = 3 * DATA_WIDTH + 1;

    localparam logic [6:0] WORD_CNT = 7'(DATA_WIDTH);
    localparam logic [6:0] BLK_CNT  = 7'(BLK_W);

    logic [BUF_W-1:0] r_buf;
    logic [6:0]       r_cnt;
    logic             r_pending;

    logic [BUF_W-1:0] w_buf_a;
    logic [6:0]       w_cnt_a;
    logic             w_emit;
    logic [BLK_W-1:0] w_blk;
    logic [BUF_W-1:0] w_buf_e;
    logic [6:0]       w_cnt_e;
    logic             w_do_slip;
    logic [BUF_W-1:0] w_buf_n;
    logic [6:0]       w_cnt_n;
    logic             w_slip_req;
    logic             w_pend_n;

    // Bits above r_cnt are always zero, so an OR places the new word.
    always_comb begin
        w_buf_a = r_buf;
        w_cnt_a = r_cnt;
        if (i_data_valid) begin
            w_buf_a = r_buf | (BUF_W'(i_data) << r_cnt);
            w_cnt_a = r_cnt + WORD_CNT;
        end
    end

    // The block is taken before any slip, so a slip never touches it.
    always_comb begin
        w_emit  = (w_cnt_a >= BLK_CNT);
        w_blk   = w_buf_a[BLK_W-1:0];
        w_buf_e = w_buf_a;
        w_cnt_e = w_cnt_a;
        if (w_emit) begin
            w_buf_e = w_buf_a >> BLK_W;
            w_cnt_e = w_cnt_a - BLK_CNT;
        end
    end

    // Slip waits in r_pending until at least one bit is buffered.
    always_comb begin
        w_do_slip = r_pending && (w_cnt_e != 7'd0);
        w_buf_n   = w_buf_e;
        w_cnt_n   = w_cnt_e;
        if (w_do_slip) begin
            w_buf_n = w_buf_e >> 1;
            w_cnt_n = w_cnt_e - 7'd1;
        end
    end

    // A request arriving while one is pending merges into it.
    always_comb begin
        w_pend_n = r_pending | w_slip_req;
        if (w_do_slip) begin
            w_pend_n = 1'b0;
        end
    end

`ifdef RX_GEARBOX_SLIP_HOLDOFF_EN
    logic [1:0] r_hold;

    assign w_slip_req = i_slip && (r_hold == 2'd0);

    // Counts down emitted blocks after an applied slip.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hold <= 2'd0;
        end else if (w_do_slip) begin
            r_hold <= 2'd2;
        end else if (w_emit && (r_hold != 2'd0)) begin
            r_hold <= r_hold - 2'd1;
        end
    end
`else
    assign w_slip_req = i_slip;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_buf     <= '0;
            r_cnt     <= 7'd0;
            r_pending <= 1'b0;
        end else begin
            r_buf     <= w_buf_n;
            r_cnt     <= w_cnt_n;
            r_pending <= w_pend_n;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_hdr        <= '0;
            o_data       <= '0;
            o_hdr_valid  <= 1'b0;
            o_data_valid <= 1'b0;
        end else begin
            o_hdr_valid  <= w_emit;
            o_data_valid <= w_emit;
            if (w_emit) begin
                o_hdr  <= w_blk[HDR_WIDTH-1:0];
                o_data <= w_blk[BLK_W-1:HDR_WIDTH];
            end
        end
    end

endmodule

// File: doc/rx_gearbox.md
RX_GEARBOX -- requirements
Module: rx_gearbox

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: input word width; only 32 is supported.
REQ-002 SHALL have parameter HDR_WIDTH, default 2: sync header width.
REQ-003 SHALL have port i_clk  input  1  rx clock, rising-edge active.
REQ-004 SHALL have port i_reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_data  input  32  serial bits from the transceiver; i_data[0] is the earliest received bit.
REQ-006 SHALL have port i_data_valid  input  1  i_data is accepted on this cycle.
REQ-007 SHALL have port i_slip  input  1  single-cycle request from the lock FSM to shift alignment by one bit.
REQ-008 SHALL have port o_hdr  output  2  sync header, i.e. the first two bits of the block.
REQ-009 SHALL have port o_data  output  64  block payload, i.e. bits 2..65 of the block.
REQ-010 SHALL have port o_hdr_valid  output  1  o_hdr is valid; feeds the lock FSM i_hdr_valid.
REQ-011 SHALL have port o_data_valid  output  1  o_data is valid; asserted in the same cycles as o_hdr_valid.

Function
REQ-012 SHALL hold a 97-bit buffer and a 7-bit bit count (range 0..65 between cycles); the oldest bit is at buffer bit 0.
REQ-013 Per cycle, the ordered steps SHALL be: append (if i_data_valid) -> emit -> slip.
REQ-014 Append: i_data SHALL be placed at buffer bits [count+31:count], and count SHALL increase by 32.
REQ-015 Emit: if count >= 66, the block buffer[65:0] SHALL be registered; next cycle o_hdr = buffer[1:0], o_data = buffer[65:2], o_hdr_valid = o_data_valid = 1.
REQ-016 Emit: the buffer SHALL shift right by 66 and count SHALL decrease by 66.
REQ-017 o_hdr_valid SHALL be a single-cycle pulse per block; o_hdr/o_data SHALL hold their last value while valid is low.
REQ-018 Latency: the block SHALL be visible one cycle after the word that completes it is sampled.
REQ-019 Latency from reset: three consecutive valid words SHALL give the first o_hdr_valid in the cycle after the third word.
REQ-020 Throughput: 33 consecutive valid words SHALL yield exactly 16 blocks, and count SHALL return to its starting value.
REQ-021 i_slip SHALL set a pending flag.
REQ-022 Slip: if pending and the post-emit count >= 1, the oldest bit SHALL be dropped (buffer >> 1, count - 1) and pending SHALL clear.
REQ-023 Slip with a post-emit count of 0 SHALL leave pending set until bits are available.
REQ-024 i_slip while pending is already set SHALL be merged (no second bit dropped).
REQ-025 A slip SHALL never alter a block already selected for emission in the same cycle.
REQ-026 No valid input: count SHALL hold, no block SHALL be emitted, and a pending slip SHALL still apply if count >= 1.
REQ-027 The block SHALL NOT check header validity; 00/11 headers SHALL pass through unchanged.

Reset
REQ-028 On i_reset_n low, the following SHALL clear asynchronously at any time, including mid-block: count = 0, buffer = 0, pending = 0, o_hdr = 0, o_data = 0, o_hdr_valid = 0, o_data_valid = 0.
REQ-029 After release, the first accepted word SHALL be treated as bit 0 of a new alignment.

Configuration
REQ-030 Macro RX_GEARBOX_SLIP_HOLDOFF_EN: when defined, after an applied slip further i_slip SHALL be ignored until two blocks have been emitted (2-bit holdoff counter).
REQ-031 Without RX_GEARBOX_SLIP_HOLDOFF_EN: every i_slip SHALL be honoured per REQ-021..024, and no holdoff logic SHALL exist.

Verification
REQ-032 Reset, then 33 valid words of aligned stream, header 01 in every block, payload = block index -> 16 pulses with o_hdr = 01 and o_data = 0..15; first pulse in the cycle after word 3.
REQ-033 Same stream with i_data_valid low every other cycle -> identical 16 blocks; no pulse during gaps; count constant during gaps.
REQ-034 Stream pre-shifted by 5 bits; pulse i_slip 5 times, each after an emitted block -> all subsequent o_hdr in {01,10} and payload matches the source.
REQ-035 i_slip in the cycle count reaches 66 -> that block is unshifted; the next block starts one bit later.
REQ-036 i_reset_n low for 1 cycle with count = 40 -> all outputs 0 immediately; the following three words give the first block per REQ-019.
REQ-037 With RX_GEARBOX_SLIP_HOLDOFF_EN, i_slip high 2 consecutive cycles -> exactly one bit dropped; without the macro -> one bit dropped (merged) per REQ-024.
